parity_nibble_rx: RTL and testbench
===================================

Name: parity_nibble_rx

Overview:
- Serial receiver directly upstream of the 4-bit parity generator/checker stage.
- Deserializes frames of 1 start bit, 4 data bits (LSB first), 1 parity bit and 1 stop bit from a single-wire line.
- Checks parity and framing, then presents the nibble plus status on a valid/ready interface to the 4-bit parity stage.
- Keeps a saturating error count for diagnostics.

Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit; must be an even number ≥ 2.
- ODD_PARITY, 0: 0 selects even parity, 1 selects odd parity.
- ERR_CNT_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  serial line; idles high; asynchronous to clk.
- data_out  out  4  received nibble.
- parity_bit_out  out  1  received parity bit, so the downstream stage can re-check it.
- data_valid  out  1  data_out, parity_bit_out and parity_err are valid.
- data_ready  in  1  downstream accepts the current frame.
- parity_err  out  1  parity mismatch on the presented frame.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky; a frame completed while data_valid was high and data_ready was low.
- err_count  out  ERR_CNT_W  saturating count of parity errors, frame errors and overruns.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - data_out = 0, parity_bit_out = 0, data_valid = 0.
  - parity_err = 0, frame_err = 0, overrun = 0.
  - err_count = 0, busy = 0.
  - Synchronizer flops = 1; FSM = IDLE.
- Input synchronizer:
  - rx_in passes through a 2-flop synchronizer (rx_s).
  - All references below are to rx_s; this adds 2 cycles of input latency.
- Bit timer:
  - Counter runs 0..CLKS_PER_BIT-1.
  - Cleared on entry to START.
  - Produces a "sample" strobe at count CLKS_PER_BIT/2-1 in START, and at count CLKS_PER_BIT-1 in every later state, so sampling lands mid-bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 -> START.
  - START: on sample, rx_s==0 -> DATA with the timer restarted. rx_s==1 is a glitch -> IDLE, with no error and no count.
  - DATA: on each sample, shift rx_s into bit index 0..3 (LSB first). After the 4th sample -> PARITY.
  - PARITY: on sample, capture the parity bit -> STOP.
  - STOP, on sample, rx_s==1:
    - Commit the frame, then -> IDLE.
    - parity_err = (^data ^ parity_bit) != ODD_PARITY.
    - Commit means: load data_out, parity_bit_out and parity_err, and set data_valid.
  - STOP, on sample, rx_s==0:
    - Pulse frame_err for 1 cycle, increment err_count and discard the frame.
    - Go to IDLE. IDLE does not re-arm until rx_s==1 has been seen for one cycle.
- Output handshake:
  - data_valid stays high until a cycle with data_ready==1. That cycle completes the transfer, and data_valid drops next cycle.
  - Output registers stay stable while data_valid is high.
- Commit while data_valid && !data_ready (overrun):
  - The new frame is dropped and the held frame is kept.
  - overrun is set (sticky until rst) and err_count increments.
- Commit in the same cycle as an accepting data_ready:
  - The handshake completes and the new frame loads.
  - data_valid stays high with no gap.
- Committed frame with parity_err=1: still presented to downstream, and err_count increments once.
- err_count saturates at all-ones; it never wraps.
- busy = (state != IDLE).
- Latency: data_valid rises 1 cycle after the STOP sample strobe. The STOP sample is mid stop bit.
- Reset mid-frame: the next cycle is in IDLE with all outputs at reset values, and the partial frame is discarded.

Decomposition:
- Package parity_rx_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Constant DATA_BITS = 4.
  - Constants EVEN_PARITY = 0 and ODD_PARITY_SEL = 1.
- One sub-module, bit_timer: the mid-bit sample strobe generator, with inputs clear/enable/first_bit and output sample.
- The synchronizer, FSM and output register live in the top module.

Test Plan:
All cases use CLKS_PER_BIT=4, ODD_PARITY=0 and data_ready=1 unless stated.
- Frame 0,1101(LSB first = 4'b1011),1,1 -> data_out=4'b1011, parity_bit_out=1, parity_err=0, data_valid for 1 cycle, err_count=0.
- Frame for 4'b1011 with parity bit 0 -> data_valid with parity_err=1, err_count=1.
- Frame for 4'b0110 with parity 0 and stop bit 0 -> frame_err 1-cycle pulse, no data_valid, err_count=1; a following good frame 4'b0001, parity 1 is received correctly.
- rx_in low for 1 clk then high -> START aborts at sample, busy drops, no data_valid, err_count=0.
- data_ready=0, two good frames 4'b0011 then 4'b1111 -> data_out holds 4'b0011, overrun=1, err_count=1; raising data_ready delivers 4'b0011 only.
- rst asserted during DATA of 4'b1010 -> all outputs 0 next cycle; the next full frame 4'b0101, parity 0 is received correctly.

Source files
------------

// File: rtl/parity_rx_pkg.sv
// Shared state encodings, widths and parity helper for the nibble receiver.
// Pure declarations: no latency, no flow control.
package parity_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int DATA_BITS      = 4;
  localparam int EVEN_PARITY    = 0;
  localparam int ODD_PARITY_SEL = 1;

  // Error when the total count of ones (data plus parity bit) breaks the selected rule.
  function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] d,
                                           input logic p,
                                           input logic odd);
    return (^d ^ p) != odd;
  endfunction

endpackage

// File: rtl/parity_nibble_rx_bit_timer.sv
// Mid-bit sample strobe: fires at CLKS_PER_BIT/2-1 for the start bit, then at CLKS_PER_BIT-1.
// Single-cycle strobe; no backpressure.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_first_bit,
  output logic o_sample
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit    = i_first_bit ? (r_cnt == HALF_M1) : (r_cnt == FULL_M1);
  assign o_sample = i_enable && w_hit;

  // Restart on every strobe so each later sample lands a full bit after the previous one.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (w_hit || r_cnt == FULL_M1) r_cnt <= '0;
      else                           r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_nibble_rx.sv
// Serial 4-bit+parity receiver; data_valid rises 1 cycle after the stop-bit sample (+2 sync cycles on rx_in).
// data_valid holds until data_ready; a frame completing while held is dropped and flagged as overrun.
module parity_nibble_rx
  import parity_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [3:0]           data_out,
  output logic                 parity_bit_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam logic P_ODD = (ODD_PARITY == ODD_PARITY_SEL);
  localparam logic [1:0] LAST_IDX = 2'(DATA_BITS - 1);

  logic                 r_rx_meta, r_rx_s;
  logic [2:0]           r_state;
  logic [1:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_armed;

  logic [3:0]           r_data;
  logic                 r_par_out, r_valid, r_perr, r_ferr, r_ovr;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic w_sample, w_clear, w_start_det;
  logic w_stop_smp, w_commit, w_frame_bad, w_load, w_ovr, w_perr_new, w_err_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_start_det = (r_state == ST_IDLE) && !r_rx_s && r_armed;
  assign w_clear     = w_start_det;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_enable    (r_state != ST_IDLE),
    .i_first_bit (r_state == ST_START),
    .o_sample    (w_sample)
  );

  // A framing error leaves the line low; wait for it to idle high before hunting a new start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_armed   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_rx_s) r_armed <= 1'b1;
          if (w_start_det) begin
            r_state   <= ST_START;
            r_bit_idx <= '0;
          end
        end
        ST_START: if (w_sample) r_state <= r_rx_s ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (w_sample) begin
            r_shift[r_bit_idx] <= r_rx_s;
            r_bit_idx          <= r_bit_idx + 1'b1;
            if (r_bit_idx == LAST_IDX) r_state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (w_sample) begin
            r_par   <= r_rx_s;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_sample) begin
            r_state <= ST_IDLE;
            if (!r_rx_s) r_armed <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_stop_smp  = (r_state == ST_STOP) && w_sample;
  assign w_commit    = w_stop_smp && r_rx_s;
  assign w_frame_bad = w_stop_smp && !r_rx_s;
  assign w_load      = w_commit && (!r_valid || data_ready);
  assign w_ovr       = w_commit && r_valid && !data_ready;
  assign w_perr_new  = calc_parity_err(r_shift, r_par, P_ODD);
  assign w_err_inc   = w_frame_bad || w_ovr || (w_load && w_perr_new);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_par_out <= 1'b0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_ferr <= w_frame_bad;
      if (w_ovr) r_ovr <= 1'b1;
      if (w_load) begin
        r_data    <= r_shift;
        r_par_out <= r_par;
        r_perr    <= w_perr_new;
        r_valid   <= 1'b1;
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
      if (w_err_inc && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign data_out       = r_data;
  assign parity_bit_out = r_par_out;
  assign data_valid     = r_valid;
  assign parity_err     = r_perr;
  assign frame_err      = r_ferr;
  assign overrun        = r_ovr;
  assign err_count      = r_err_cnt;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_parity_nibble_rx.sv
// Bench for parity_nibble_rx: vector table, hand-written corner sequences and random frames
// checked against a frame-level model of the received data and error count.
module tb_parity_nibble_rx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst, rx_in, data_ready;
  logic [3:0] data_out;
  logic       parity_bit_out, data_valid, parity_err, frame_err, overrun, busy;
  logic [7:0] err_count;

  parity_nibble_rx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(0), .ERR_CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_in          (rx_in),
    .data_out       (data_out),
    .parity_bit_out (parity_bit_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .err_count      (err_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] rx_q[$];
  int valid_cycles = 0;
  int ferr_pulses  = 0;
  bit busy_seen    = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) valid_cycles++;
      if (data_valid && data_ready) rx_q.push_back({parity_err, parity_bit_out, data_out});
      if (frame_err) ferr_pulses++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
    rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      repeat (CPB) tick();
    end
    rx_in = p;
    repeat (CPB) tick();
    rx_in = s;
    repeat (CPB) tick();
    rx_in = 1'b1;
    repeat (10) tick();
  endtask

  task automatic send_and_check(input string nm, input logic [3:0] d, input logic p,
                                input logic s, input logic exp_v, input logic exp_perr,
                                input int exp_e);
    int v0, f0, q0;
    v0 = valid_cycles;
    f0 = ferr_pulses;
    q0 = rx_q.size();
    send_frame(d, p, s);
    check({nm, " valid_cycles"}, valid_cycles - v0, exp_v ? 1 : 0);
    check({nm, " frame_err_pulses"}, ferr_pulses - f0, exp_v ? 0 : 1);
    check({nm, " frames_rx"}, rx_q.size() - q0, exp_v ? 1 : 0);
    if (rx_q.size() > q0)
      check({nm, " frame"}, rx_q[rx_q.size()-1], {exp_perr, p, d});
    check({nm, " err_count"}, err_count, exp_e);
  endtask

  // Frame-level model: even parity holds when the count of ones over data and parity is even.
  int exp_err = 0;
  function automatic logic model_perr(input logic [3:0] d, input logic p);
    return ($countones({d, p}) % 2) != 0;
  endfunction
  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  typedef struct {
    logic [3:0] d;
    logic       p;
    logic       s;
    logic       exp_v;
    logic       exp_perr;
    int         exp_err;
  } vec_t;

  vec_t tab[6];

  initial begin
    int v0, q0, e0, f0, n;
    logic [3:0] rd;
    logic rp, rs, rperr;

    tab[0] = '{4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    tab[1] = '{4'b1011, 1'b0, 1'b1, 1'b1, 1'b1, 1};
    tab[2] = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    tab[3] = '{4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    tab[4] = '{4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    tab[5] = '{4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 3};

    rst = 1'b1;
    rx_in = 1'b1;
    data_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {data_out, parity_bit_out, data_valid, parity_err, frame_err,
                            overrun, err_count, busy}, 0);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 6; i++)
      send_and_check($sformatf("vec%0d", i), tab[i].d, tab[i].p, tab[i].s,
                     tab[i].exp_v, tab[i].exp_perr, tab[i].exp_err);
    exp_err = 3;

    // One-clock low glitch: START is entered but aborted at its sample point.
    v0 = valid_cycles;
    busy_seen = 1'b0;
    rx_in = 1'b0;
    tick();
    rx_in = 1'b1;
    repeat (10) tick();
    check("glitch busy_seen", busy_seen, 1);
    check("glitch busy", busy, 0);
    check("glitch valid_cycles", valid_cycles - v0, 0);
    check("glitch err_count", err_count, exp_err);

    // Overrun: second frame completes while the first is still held.
    data_ready = 1'b0;
    send_frame(4'b0011, 1'b0, 1'b1);
    send_frame(4'b1111, 1'b0, 1'b1);
    exp_err = sat_inc(exp_err);
    check("ovr data_valid", data_valid, 1);
    check("ovr data_out", data_out, 4'b0011);
    check("ovr overrun", overrun, 1);
    check("ovr err_count", err_count, exp_err);
    q0 = rx_q.size();
    data_ready = 1'b1;
    repeat (4) tick();
    check("ovr frames_rx", rx_q.size() - q0, 1);
    if (rx_q.size() > q0) check("ovr frame", rx_q[q0], {1'b0, 1'b0, 4'b0011});
    check("ovr valid_drop", data_valid, 0);
    check("ovr overrun_sticky", overrun, 1);

    // Reset while shifting data bits of 4'b1010.
    rx_in = 1'b0;
    repeat (CPB) tick();
    rx_in = 1'b0;
    repeat (CPB) tick();
    rx_in = 1'b1;
    repeat (CPB) tick();
    rst = 1'b1;
    tick();
    check("rst_mid outputs", {data_out, parity_bit_out, data_valid, parity_err, frame_err,
                              overrun, err_count, busy}, 0);
    rst = 1'b0;
    exp_err = 0;
    repeat (4) tick();
    send_and_check("post_rst", 4'b0101, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      rd = 4'($urandom_range(0, 15));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 4) != 0);
      rperr = model_perr(rd, rp);
      if (!rs || rperr) exp_err = sat_inc(exp_err);
      send_and_check($sformatf("rand%0d", i), rd, rp, rs, rs, rperr, exp_err);
    end

    // Drive the counter past all-ones with framing errors.
    e0 = exp_err;
    f0 = ferr_pulses;
    n = 258 - e0;
    for (int i = 0; i < n; i++) begin
      send_frame(4'($urandom_range(0, 15)), 1'b0, 1'b0);
      exp_err = sat_inc(exp_err);
    end
    check("sat frame_err_pulses", ferr_pulses - f0, n);
    check("sat err_count", err_count, exp_err);
    send_and_check("post_sat", 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
